// File: rtl/fusion_seq_ctrl_if.sv
// rtl/fusion_seq_ctrl_if.sv - operand/result handshake and bitbrick bus of the fusion sequencer
interface fusion_seq_ctrl_if #(
    parameter int ACC_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_w;
    logic [1:0]       prec_a;
    logic [1:0]       prec_w;
    logic             sign_a;
    logic             sign_w;
    logic [2:0]       brick_a;
    logic [2:0]       brick_w;
    logic [5:0]       brick_p;
    logic [2:0]       brick_shift;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_result;

    modport slave (
        input  in_valid, in_a, in_w, prec_a, prec_w, sign_a, sign_w, brick_p, out_ready,
        output in_ready, brick_a, brick_w, brick_shift, out_valid, out_result
    );

    modport master (
        output in_valid, in_a, in_w, prec_a, prec_w, sign_a, sign_w, brick_p, out_ready,
        input  in_ready, brick_a, brick_w, brick_shift, out_valid, out_result
    );
endinterface

// File: rtl/fusion_seq_ctrl.sv
// rtl/fusion_seq_ctrl.sv - bit-fusion multiply sequencer driving an external 2b x 2b bitbrick
module fusion_seq_ctrl #(
    parameter int ACC_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    fusion_seq_ctrl_if.slave io
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [1:0]       i_q, i_d, j_q, j_d;
    logic [1:0]       last_i_q, last_i_d, last_j_q, last_j_d;
    logic [7:0]       a_q, a_d, w_q, w_d;
    logic             sa_q, sa_d, sw_q, sw_d;
    logic [ACC_W-1:0] prod_ext;

    // Index of the most significant 2-bit chunk; 2'b11 and 2'b10 both mean 8 bits.
    function automatic logic [1:0] last_idx(input logic [1:0] prec);
        case (prec)
            2'b00:   last_idx = 2'd0;
            2'b01:   last_idx = 2'd1;
            default: last_idx = 2'd3;
        endcase
    endfunction

    function automatic logic [2:0] chunk(input logic [7:0] v, input logic [1:0] idx, input logic ext);
        logic [1:0] c;
        c     = v[{idx, 1'b0} +: 2];
        chunk = {ext & c[1], c};
    endfunction

    assign prod_ext = {{(ACC_W-6){io.brick_p[5]}}, io.brick_p};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            i_q      <= 2'd0;
            j_q      <= 2'd0;
            last_i_q <= 2'd0;
            last_j_q <= 2'd0;
            a_q      <= 8'd0;
            w_q      <= 8'd0;
            sa_q     <= 1'b0;
            sw_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            i_q      <= i_d;
            j_q      <= j_d;
            last_i_q <= last_i_d;
            last_j_q <= last_j_d;
            a_q      <= a_d;
            w_q      <= w_d;
            sa_q     <= sa_d;
            sw_q     <= sw_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        i_d            = i_q;
        j_d            = j_q;
        last_i_d       = last_i_q;
        last_j_d       = last_j_q;
        a_d            = a_q;
        w_d            = w_q;
        sa_d           = sa_q;
        sw_d           = sw_q;
        io.in_ready    = 1'b0;
        io.out_valid   = 1'b0;
        io.out_result  = '0;
        io.brick_a     = 3'd0;
        io.brick_w     = 3'd0;
        io.brick_shift = 3'd0;

        case (state_q)
            IDLE: begin
                io.in_ready = 1'b1;
                if (io.in_valid) begin
                    a_d      = io.in_a;
                    w_d      = io.in_w;
                    last_i_d = last_idx(io.prec_a);
                    last_j_d = last_idx(io.prec_w);
                    sa_d     = io.sign_a;
                    sw_d     = io.sign_w;
                    acc_d    = '0;
                    i_d      = 2'd0;
                    j_d      = 2'd0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Only the top chunk of a signed operand carries the sign.
                io.brick_a     = chunk(a_q, i_q, sa_q && (i_q == last_i_q));
                io.brick_w     = chunk(w_q, j_q, sw_q && (j_q == last_j_q));
                io.brick_shift = {1'b0, i_q} + {1'b0, j_q};
                acc_d          = acc_q + (prod_ext << {io.brick_shift, 1'b0});
                if (j_q == last_j_q) begin
                    j_d = 2'd0;
                    if (i_q == last_i_q) begin
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 2'd1;
                    end
                end else begin
                    j_d = j_q + 2'd1;
                end
            end
            DONE: begin
                io.out_valid  = 1'b1;
                io.out_result = acc_q;
                if (io.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fusion_seq_ctrl.sv
// tb/tb_fusion_seq_ctrl.sv - scoreboard bench for fusion_seq_ctrl with a behavioural bitbrick
module tb_fusion_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fusion_seq_ctrl_if #(.ACC_W(16)) bus();

    fusion_seq_ctrl #(.ACC_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (bus.slave)
    );

    logic [5:0] pa6, pw6;
    assign pa6 = {{3{bus.brick_a[2]}}, bus.brick_a};
    assign pw6 = {{3{bus.brick_w[2]}}, bus.brick_w};
    assign bus.brick_p = pa6 * pw6;

    typedef struct packed {
        logic [15:0] res;
        logic [7:0]  lat;
    } res_t;

    res_t       res_q[$];
    logic [8:0] step_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int nchunks(input logic [1:0] p);
        return (p == 2'b00) ? 1 : ((p == 2'b01) ? 2 : 4);
    endfunction

    task automatic push_steps(input logic [7:0] a, input logic [7:0] w, input logic [1:0] pa,
                              input logic [1:0] pw, input logic sa, input logic sw, input int limit);
        int na, nw, cnt;
        logic [7:0] as, ws;
        logic [2:0] ba, bw, k;
        na  = nchunks(pa);
        nw  = nchunks(pw);
        cnt = 0;
        for (int i = 0; i < na; i++) begin
            for (int j = 0; j < nw; j++) begin
                as = a >> (2 * i);
                ws = w >> (2 * j);
                ba = {(sa && i == na - 1) ? as[1] : 1'b0, as[1:0]};
                bw = {(sw && j == nw - 1) ? ws[1] : 1'b0, ws[1:0]};
                k  = 3'(i + j);
                if (cnt < limit) step_q.push_back({k, ba, bw});
                cnt++;
            end
        end
    endtask

    // Monitor: checks every RUN step and every accepted result against the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!bus.in_ready && !bus.out_valid) begin
                if (step_q.size() == 0) check("step_unexpected", {bus.brick_shift, bus.brick_a, bus.brick_w}, 32'h0_dead);
                else check("step", {bus.brick_shift, bus.brick_a, bus.brick_w}, step_q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) acc_cyc = cyc;
            if (bus.out_valid && !prev_valid) begin
                if (res_q.size() == 0) check("valid_unexpected", bus.out_result, 32'h0_dead);
                else check("latency", cyc - acc_cyc, res_q[0].lat);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (res_q.size() == 0) check("result_unexpected", bus.out_result, 32'h0_dead);
                else check("result", bus.out_result, res_q.pop_front().res);
            end
            prev_valid = bus.out_valid;
        end else begin
            prev_valid = 1'b0;
        end
    end

    task automatic wait_empty();
        int n = 0;
        while (res_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("result_timeout", res_q.size(), 0);
    endtask

    task automatic drive_op(input logic [7:0] a, input logic [7:0] w, input logic [1:0] pa,
                            input logic [1:0] pw, input logic sa, input logic sw);
        int n = 0;
        @(posedge clk); #1;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        bus.in_valid = 1'b1;
        bus.in_a = a;  bus.in_w = w;
        bus.prec_a = pa; bus.prec_w = pw;
        bus.sign_a = sa; bus.sign_w = sw;
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] w, input logic [1:0] pa,
                          input logic [1:0] pw, input logic sa, input logic sw,
                          input logic [15:0] exp, input int runs, input bit wait_done);
        push_steps(a, w, pa, pw, sa, sw, 99);
        res_q.push_back({exp, 8'(runs + 1)});
        drive_op(a, w, pa, pw, sa, sw);
        bus.in_a = ~a; bus.in_w = a ^ w;
        bus.prec_a = pw; bus.prec_w = pa;
        bus.sign_a = ~sa; bus.sign_w = ~sw;
        repeat (runs / 2) begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (wait_done) wait_empty();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seen;
        bus.in_valid = 1'b0; bus.in_a = 8'd0; bus.in_w = 8'd0;
        bus.prec_a = 2'd0; bus.prec_w = 2'd0; bus.sign_a = 1'b0; bus.sign_w = 1'b0;
        bus.out_ready = 1'b1;
        #2;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out", {bus.out_valid, bus.out_result}, 0);
        check("rst_brick", {bus.brick_a, bus.brick_w, bus.brick_shift}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        run_op(8'h03, 8'h01, 2'd0, 2'd0, 1'b1, 1'b1, 16'hFFFF, 1, 1);
        run_op(8'hFF, 8'hFF, 2'd2, 2'd2, 1'b0, 1'b0, 16'hFE01, 16, 1);
        run_op(8'h80, 8'h7F, 2'd2, 2'd2, 1'b1, 1'b1, 16'hC080, 16, 1);
        run_op(8'h0D, 8'd100, 2'd1, 2'd2, 1'b1, 1'b1, 16'hFED4, 8, 1);
        run_op(8'hF6, 8'h03, 2'd3, 2'd3, 1'b1, 1'b1, 16'hFFE2, 16, 1);
        run_op(8'h0F, 8'h0D, 2'd1, 2'd1, 1'b0, 1'b0, 16'h00C3, 4, 1);
        run_op(8'hAE, 8'hC8, 2'd0, 2'd2, 1'b1, 1'b0, 16'hFE70, 4, 1);

        bus.out_ready = 1'b0;
        run_op(8'h07, 8'h09, 2'd1, 2'd1, 1'b1, 1'b1, 16'hFFCF, 4, 0);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_wait", bus.out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            check("bp_result", {bus.out_valid, bus.out_result}, {1'b1, 16'hFFCF});
            check("bp_in_ready", bus.in_ready, 0);
        end
        @(posedge clk); #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_handshake_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        check("bp_idle", {bus.in_ready, bus.out_valid}, 2'b10);
        wait_empty();

        push_steps(8'hFF, 8'hFF, 2'd2, 2'd2, 1'b0, 1'b0, 3);
        drive_op(8'hFF, 8'hFF, 2'd2, 2'd2, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_out", {bus.out_valid, bus.out_result}, 0);
        check("abort_brick", {bus.brick_a, bus.brick_w, bus.brick_shift}, 0);
        check("abort_steps", step_q.size(), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort_no_valid", seen, 0);

        run_op(8'h02, 8'h03, 2'd0, 2'd0, 1'b0, 1'b0, 16'h0006, 1, 1);
        check("queues_empty", res_q.size() + step_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
